// File: rtl/data_mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_mem_responder_if                                     |
// | Brief    : Request/response handshake bundle for the data memory.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_mem_responder                                        |
// | Brief    : Fixed-latency word memory target for the core's data port.|
// |            Optional DMEM_MISALIGN_CHECK_EN flags misaligned accesses. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  wire logic            clock,
   input  wire logic            reset,
   data_mem_responder_if.slave  bus
);
   localparam int         c_idx_w    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] c_cnt_load = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_cnt;
   logic               r_write;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic [3:0]         r_wstrb;
   logic [31:0]        r_rdata;
   logic               r_err;
   logic [31:0]        r_mem [DEPTH_WORDS];

   logic               w_accept;
   logic               w_access;
   logic               w_range_err;
   logic               w_align_err;
   logic               w_err;
   logic [c_idx_w-1:0] w_idx;

   assign w_accept    = bus.req_valid && (r_state == ST_IDLE);
   assign w_access    = (r_state == ST_WAIT) && (r_cnt == 4'd0);
   assign w_idx       = r_addr[c_idx_w+1:2];
   assign w_range_err = |r_addr[31:c_idx_w+2];
   assign w_err       = w_range_err || w_align_err;

`ifdef DMEM_MISALIGN_CHECK_EN
   // Stores must use a naturally aligned byte/halfword/word lane pattern
   // whose lowest lane matches the address offset.
   always_comb begin
      w_align_err = 1'b0;
      if (!r_write) begin
         w_align_err = (r_addr[1:0] != 2'd0);
      end else begin
         case (r_wstrb)
            4'b0001, 4'b0011, 4'b1111: w_align_err = (r_addr[1:0] != 2'd0);
            4'b0010:                   w_align_err = (r_addr[1:0] != 2'd1);
            4'b0100, 4'b1100:          w_align_err = (r_addr[1:0] != 2'd2);
            4'b1000:                   w_align_err = (r_addr[1:0] != 2'd3);
            default:                   w_align_err = 1'b1;
         endcase
      end
   end
`else
   logic w_unused_lsb;
   assign w_align_err  = 1'b0;
   assign w_unused_lsb = ^r_addr[1:0];
`endif

   always_comb begin
      w_state_nxt   = r_state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_write <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_wstrb <= 4'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt   <= c_cnt_load;
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_wstrb <= bus.req_wstrb;
         end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_access) begin
            r_err   <= w_err;
            r_rdata <= (w_err || r_write) ? 32'd0 : r_mem[w_idx];
         end
      end
   end

   // Storage is not reset; a reset during WAIT leaves r_state idle so the
   // pending store never reaches this block.
   always_ff @(posedge clock) begin
      if (w_access && r_write && !w_err) begin
         for (int i = 0; i < 4; i++) begin
            if (r_wstrb[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_data_mem_responder                                     |
// | Brief    : Directed table, corner sequences and random traffic       |
// |            against a word-array reference model.                     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_data_mem_responder;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   data_mem_responder_if bus();

   data_mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_mem [DEPTH];

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int          bp;
      logic [31:0] exp_rd;
      logic        exp_er;
   } vec_t;

   vec_t tbl [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

`ifdef DMEM_MISALIGN_CHECK_EN
   function automatic logic strb_ok(input logic [3:0] s, input logic [1:0] lo);
      case (s)
         4'b0001: return lo == 2'd0;
         4'b0010: return lo == 2'd1;
         4'b0100: return lo == 2'd2;
         4'b1000: return lo == 2'd3;
         4'b0011: return lo == 2'd0;
         4'b1100: return lo == 2'd2;
         4'b1111: return lo == 2'd0;
         default: return 1'b0;
      endcase
   endfunction
`endif

   // Reference: classify the access, then apply it to the word array
   task automatic predict(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic er);
      int idx;
      er = (a >= 32'(4 * DEPTH));
`ifdef DMEM_MISALIGN_CHECK_EN
      if (!w && a[1:0] != 2'd0) er = 1'b1;
      if (w && !strb_ok(s, a[1:0])) er = 1'b1;
`endif
      rd  = 32'd0;
      idx = int'(a / 4);
      if (!er) begin
         if (w) begin
            for (int i = 0; i < 4; i++)
               if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
         end else begin
            rd = model_mem[idx];
         end
      end
   endtask

   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int bp,
                       output logic [31:0] rd, output logic er);
      int cyc;
      @(negedge clock);
      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wstrb = s;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_wstrb = 4'($urandom);
      check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      cyc = 0;
      while (!bus.rsp_valid && cyc < 40) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      check("rsp_latency", 32'(cyc), 32'(LAT));
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
      // Under backpressure, offer a competing store that must not be taken
      for (int k = 0; k < bp; k++) begin
         bus.req_valid = 1'b1;
         bus.req_write = 1'b1;
         bus.req_addr  = 32'($urandom_range(0, 63)) & 32'hFFFF_FFFC;
         bus.req_wdata = $urandom;
         bus.req_wstrb = 4'b1111;
         @(posedge clock);
         #1;
         check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("bp_rdata_stable", bus.rsp_rdata, rd);
         check("bp_err_stable", 32'(bus.rsp_err), 32'(er));
         check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      check("post_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
   endtask

   task automatic run_one(input string name, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input int bp);
      logic [31:0] exp_rd, rd;
      logic        exp_er, er;
      predict(w, a, d, s, exp_rd, exp_er);
      xact(w, a, d, s, bp, rd, er);
      check({name, "_rdata"}, rd, exp_rd);
      check({name, "_err"}, 32'(er), 32'(exp_er));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd, mrd;
      logic        er, mer;
      logic        w;
      logic [31:0] a;

      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'd0;
      bus.req_wdata = 32'd0;
      bus.req_wstrb = 4'd0;
      bus.rsp_ready = 1'b0;

      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rdata", bus.rsp_rdata, 32'd0);
      check("rst_err", 32'(bus.rsp_err), 32'd0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;

      tbl.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 0, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h10,  32'h0,        4'b0000, 0, 32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 32'h10,  32'h000000AA, 4'b0001, 0, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h10,  32'h0,        4'b0000, 0, 32'hDEADBEAA, 1'b0});
      tbl.push_back('{1'b1, 32'h0,   32'h11223344, 4'b1111, 0, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 32'h3FC, 32'hCAFEF00D, 4'b1111, 0, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h400, 32'h0,        4'b0000, 0, 32'h0,        1'b1});
      tbl.push_back('{1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111, 0, 32'h0,        1'b1});
      tbl.push_back('{1'b0, 32'h0,   32'h0,        4'b0000, 0, 32'h11223344, 1'b0});
      tbl.push_back('{1'b0, 32'h3FC, 32'h0,        4'b0000, 0, 32'hCAFEF00D, 1'b0});
`ifdef DMEM_MISALIGN_CHECK_EN
      tbl.push_back('{1'b1, 32'h10,  32'h55555555, 4'b0000, 0, 32'h0,        1'b1});
`else
      tbl.push_back('{1'b1, 32'h10,  32'h55555555, 4'b0000, 0, 32'h0,        1'b0});
`endif
      tbl.push_back('{1'b0, 32'h10,  32'h0,        4'b0000, 5, 32'hDEADBEAA, 1'b0});
`ifdef DMEM_MISALIGN_CHECK_EN
      tbl.push_back('{1'b0, 32'h13,  32'h0,        4'b0000, 0, 32'h0,        1'b1});
`else
      tbl.push_back('{1'b0, 32'h13,  32'h0,        4'b0000, 0, 32'hDEADBEAA, 1'b0});
`endif
      tbl.push_back('{1'b1, 32'h20,  32'hA5A5A5A5, 4'b1111, 0, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 32'h12,  32'h77660000, 4'b1100, 1, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h10,  32'h0,        4'b0000, 0, 32'h7766BEAA, 1'b0});
      tbl.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,   4'b0000, 0, 32'h0,        1'b1});

      for (int i = 0; i < tbl.size(); i++) begin
         predict(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, mrd, mer);
         xact(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].bp, rd, er);
         check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
         check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_er));
      end

      // Reset while the store to 0x20 is still waiting
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h20;
      bus.req_wdata = 32'h12345678;
      bus.req_wstrb = 4'b1111;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("midwait_req_ready", 32'(bus.req_ready), 32'd1);
      check("midwait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midwait_rdata", bus.rsp_rdata, 32'd0);
      check("midwait_err", 32'(bus.rsp_err), 32'd0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      run_one("after_midwait_load", 1'b0, 32'h20, 32'h0, 4'b0000, 0);

      // Random traffic over a known-initialised window
      for (int i = 0; i < 16; i++)
         run_one("init_store", 1'b1, 32'(i * 4), $urandom, 4'b1111, 0);
      for (int i = 0; i < 80; i++) begin
         w = 1'($urandom);
         case ($urandom_range(0, 7))
            0:       a = 32'h400 + 32'($urandom_range(0, 255));
            1:       a = $urandom | 32'h8000_0000;
            default: a = 32'($urandom_range(0, 63));
         endcase
         run_one("rand", w, a, $urandom, 4'($urandom), $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
